// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO with a valid/ready write port feeding a
// tick-driven serialiser (start, 8 data bits LSB first, optional parity, 1-2 stop bits).
module uart_tx_buffered #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_tick_i,
  input  logic                     in_valid_i,
  input  logic [7:0]               in_data_i,
  output logic                     in_ready_o,
  output logic                     tx_pin_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(OVERSAMPLE * 2);

  localparam logic [SW-1:0] BitLast  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] StopLast = SW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]    b_cnt_q, b_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;

  // Ready looks only at the registered count, so a pop at full cannot admit a write.
  assign in_ready_o   = (count_q != CountFull);
  assign push         = in_valid_i && in_ready_o;
  assign tx_pin_o     = tx_q;
  assign busy_o       = (state_q != StIdle);
  assign fifo_count_o = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          s_cnt_d = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (s_tick_i) begin
          if (s_cnt_q == BitLast) begin
            s_cnt_d = '0;
            b_cnt_d = '0;
            tx_d    = shift_q[0];
            state_d = StData;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick_i) begin
          if (s_cnt_q == BitLast) begin
            s_cnt_d = '0;
            if (b_cnt_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_d    = (^shift_q) ^ 1'(PARITY_ODD);
                state_d = StParity;
              end else begin
                tx_d    = 1'b1;
                state_d = StStop;
              end
            end else begin
              b_cnt_d = b_cnt_q + 3'd1;
              tx_d    = shift_q[b_cnt_q + 3'd1];
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      StParity: begin
        if (s_tick_i) begin
          if (s_cnt_q == BitLast) begin
            s_cnt_d = '0;
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick_i) begin
          if (s_cnt_q == StopLast) begin
            s_cnt_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              tx_d    = 1'b0;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      s_cnt_q  <= '0;
      b_cnt_q  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_cnt_q  <= s_cnt_d;
      b_cnt_q  <= b_cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule
